// File: rtl/pattern_bank_if.sv
// Framed serial configuration port of the pattern bank: frame enable, data in/out
// and the single-cycle commit / frame-error strobes.
interface pattern_bank_if;
    logic ssel;
    logic sin;
    logic sout;
    logic commit;
    logic frame_err;

    modport master (output ssel, output sin, input sout, input commit, input frame_err);
    modport slave  (input ssel, input sin, output sout, output commit, output frame_err);
endinterface

// File: rtl/pattern_bank.sv
// Pattern-buffer bank: NBUFS buffers plus NGLOBAL global registers, loaded and read back
// over a framed serial port through a shadow register that commits atomically at frame end.
module pattern_bank #(
    parameter int WIDTH   = 8,
    parameter int BUFSIZE = 27,
    parameter int NBUFS   = 8,
    parameter int NGLOBAL = 3
) (
    input  logic                               sclk,
    input  logic                               rst,
    pattern_bank_if.slave                      sif,
    input  logic [$clog2(NBUFS)-1:0]           bufp,
    input  logic [$clog2(NGLOBAL+BUFSIZE)-1:0] fieldp,
    output logic [WIDTH-1:0]                   field_byte,
    output logic [NGLOBAL*WIDTH-1:0]           pattern_sequence
);

    localparam int AW       = $clog2(NBUFS + 1);
    localparam int BW       = $clog2(NBUFS);
    localparam int FW       = $clog2(NGLOBAL + BUFSIZE);
    localparam int GW       = (NGLOBAL > 1) ? $clog2(NGLOBAL) : 1;
    localparam int BUF_BITS = BUFSIZE * WIDTH;
    localparam int GLB_BITS = NGLOBAL * WIDTH;
    localparam int SH_BITS  = (BUF_BITS > GLB_BITS) ? BUF_BITS : GLB_BITS;
    localparam int CW       = $clog2(SH_BITS + 1);

    localparam logic [AW-1:0] GLB_ADDR = AW'(NBUFS);
    localparam logic [CW-1:0] HDR_LAST = CW'(AW);
    localparam logic [CW-1:0] BUF_LAST = CW'(BUF_BITS - 1);
    localparam logic [CW-1:0] GLB_LAST = CW'(GLB_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_RDATA,
        S_WAIT
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [AW-1:0]        addr_q;
    logic                 wr_q;
    logic                 long_q;
    logic [SH_BITS-1:0]   shadow_q;
    logic                 sout_q, sout_d;
    logic                 commit_q, commit_d;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     field_q, fetch_d;
    logic [WIDTH-1:0]     buf_q [NBUFS][BUFSIZE];
    logic [WIDTH-1:0]     glb_q [NGLOBAL];
    logic [SH_BITS-1:0]   rd_flat;
    logic [FW-1:0]        widx;
    logic                 data_last;

    assign data_last = (cnt_q == ((addr_q == GLB_ADDR) ? GLB_LAST : BUF_LAST));

    // Readback image of the addressed target, first serial bit in the MSB.
    always_comb begin
        rd_flat = '0;
        if (addr_q == GLB_ADDR) begin
            for (int g = 0; g < NGLOBAL; g++)
                rd_flat[SH_BITS-1-g*WIDTH -: WIDTH] = glb_q[g];
        end else if (addr_q < GLB_ADDR) begin
            for (int w = 0; w < BUFSIZE; w++)
                rd_flat[SH_BITS-1-w*WIDTH -: WIDTH] = buf_q[addr_q[BW-1:0]][w];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!sif.ssel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_HDR;
                S_HDR:   if (cnt_q == HDR_LAST) state_d = sif.sin ? S_RDATA : S_WDATA;
                S_WDATA,
                S_RDATA: if (data_last) state_d = S_WAIT;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        commit_d = 1'b0;
        err_d    = 1'b0;
        sout_d   = 1'b0;
        case (state_q)
            S_HDR: begin
                if (!sif.ssel)                          err_d  = 1'b1;
                else if (cnt_q == HDR_LAST && sif.sin)  sout_d = rd_flat[SH_BITS-1];
            end
            S_WDATA: if (!sif.ssel) err_d = 1'b1;
            S_RDATA: if (sif.ssel && !data_last) sout_d = shadow_q[SH_BITS-1];
            S_WAIT: begin
                // A long frame is flagged once; its closing edge then reports nothing.
                if (sif.ssel) begin
                    err_d = !long_q;
                end else if (!long_q) begin
                    if (addr_q > GLB_ADDR) err_d    = 1'b1;
                    else                   commit_d = wr_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            long_q   <= 1'b0;
            shadow_q <= '0;
            sout_q   <= 1'b0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
            field_q  <= '0;
        end else begin
            sout_q   <= sout_d;
            commit_q <= commit_d;
            err_q    <= err_d;
            field_q  <= fetch_d;
            if (sif.ssel) begin
                case (state_q)
                    S_IDLE: begin
                        addr_q <= {addr_q[AW-2:0], sif.sin};
                        cnt_q  <= CW'(1);
                        long_q <= 1'b0;
                    end
                    S_HDR: begin
                        if (cnt_q == HDR_LAST) begin
                            wr_q  <= !sif.sin;
                            cnt_q <= '0;
                            if (sif.sin) shadow_q <= rd_flat << 1;
                        end else begin
                            addr_q <= {addr_q[AW-2:0], sif.sin};
                            cnt_q  <= cnt_q + CW'(1);
                        end
                    end
                    S_WDATA: begin
                        shadow_q <= {shadow_q[SH_BITS-2:0], sif.sin};
                        cnt_q    <= cnt_q + CW'(1);
                    end
                    S_RDATA: begin
                        shadow_q <= shadow_q << 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
                    S_WAIT:  long_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the buffers are flops rather than RAM because they must clear on reset.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBUFS; b++)
                for (int w = 0; w < BUFSIZE; w++)
                    buf_q[b][w] <= '0;
            for (int g = 0; g < NGLOBAL; g++)
                glb_q[g] <= '0;
        end else if (commit_d) begin
            if (addr_q == GLB_ADDR) begin
                for (int g = 0; g < NGLOBAL; g++)
                    glb_q[g] <= shadow_q[GLB_BITS-1-g*WIDTH -: WIDTH];
            end else begin
                for (int w = 0; w < BUFSIZE; w++)
                    buf_q[addr_q[BW-1:0]][w] <= shadow_q[BUF_BITS-1-w*WIDTH -: WIDTH];
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        fetch_d = '0;
        widx    = fieldp - FW'(NGLOBAL);
        if (int'(fieldp) < NGLOBAL)
            fetch_d = glb_q[fieldp[GW-1:0]];
        else if (int'(fieldp) < NGLOBAL + BUFSIZE && int'(bufp) < NBUFS)
            fetch_d = buf_q[bufp][widx];
    end

    always_comb begin
        pattern_sequence = '0;
        for (int g = 0; g < NGLOBAL; g++)
            pattern_sequence[g*WIDTH +: WIDTH] = glb_q[g];
    end

    assign field_byte    = field_q;
    assign sif.sout      = sout_q;
    assign sif.commit    = commit_q;
    assign sif.frame_err = err_q;

endmodule

// File: tb/tb_pattern_bank.sv
// Self-checking bench for pattern_bank: frame-level model of the bank with a per-cycle
// compare process, plus literal expectations for the directed scenarios.
module tb_pattern_bank;
    localparam int WIDTH   = 8;
    localparam int BUFSIZE = 27;
    localparam int NBUFS   = 8;
    localparam int NGLOBAL = 3;
    localparam int AW      = 4;

    logic        sclk = 1'b0;
    logic        rst;
    logic [2:0]  bufp;
    logic [4:0]  fieldp;
    logic [7:0]  field_byte;
    logic [23:0] pattern_sequence;

    pattern_bank_if sif ();

    pattern_bank #(
        .WIDTH(WIDTH), .BUFSIZE(BUFSIZE), .NBUFS(NBUFS), .NGLOBAL(NGLOBAL)
    ) dut (
        .sclk(sclk),
        .rst(rst),
        .sif(sif.slave),
        .bufp(bufp),
        .fieldp(fieldp),
        .field_byte(field_byte),
        .pattern_sequence(pattern_sequence)
    );

    always #5 sclk = ~sclk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_commit_seen = 0;
    int n_err_seen = 0;

    logic [7:0] mdl_buf [NBUFS][BUFSIZE];
    logic [7:0] mdl_glb [NGLOBAL];
    logic [7:0] wbuf    [BUFSIZE];
    logic [7:0] pend_w  [BUFSIZE];
    int         pend_addr;

    logic       exp_sout, exp_commit, exp_err;
    logic [7:0] exp_field;
    bit         checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sclk) begin
        if (checking) begin
            check("sout",       32'(sif.sout),      32'(exp_sout));
            check("commit",     32'(sif.commit),    32'(exp_commit));
            check("frame_err",  32'(sif.frame_err), 32'(exp_err));
            check("field_byte", 32'(field_byte),    32'(exp_field));
            check("pattern_sequence", 32'(pattern_sequence),
                  32'({mdl_glb[2], mdl_glb[1], mdl_glb[0]}));
            if (sif.commit === 1'b1)    n_commit_seen++;
            if (sif.frame_err === 1'b1) n_err_seen++;
        end
    end

    function automatic logic model_bit(input int addr, input int k);
        if (addr < NBUFS)       return mdl_buf[addr][k/8][7-k%8];
        else if (addr == NBUFS) return mdl_glb[k/8][7-k%8];
        else                    return 1'b0;
    endfunction

    function automatic logic [7:0] model_fetch(input int b, input int f);
        if (f < NGLOBAL)           return mdl_glb[f];
        if (f < NGLOBAL + BUFSIZE) return mdl_buf[b][f-NGLOBAL];
        return 8'h00;
    endfunction

    task automatic clear_model();
        for (int b = 0; b < NBUFS; b++)
            for (int w = 0; w < BUFSIZE; w++)
                mdl_buf[b][w] = 8'h00;
        for (int g = 0; g < NGLOBAL; g++)
            mdl_glb[g] = 8'h00;
    endtask

    // One clock: drive inputs, then publish what the outputs must show after the edge.
    task automatic step(input logic s, input logic d, input logic es, input logic ec, input logic ee);
        logic [7:0] fn;
        sif.ssel = s;
        sif.sin  = d;
        fn = rst ? 8'h00 : model_fetch(int'(bufp), int'(fieldp));
        @(posedge sclk);
        #1;
        exp_sout   = es;
        exp_commit = ec;
        exp_err    = ee;
        exp_field  = fn;
        if (ec) begin
            if (pend_addr == NBUFS) begin
                for (int g = 0; g < NGLOBAL; g++) mdl_glb[g] = pend_w[g];
            end else begin
                for (int w = 0; w < BUFSIZE; w++) mdl_buf[pend_addr][w] = pend_w[w];
            end
        end
    endtask

    task automatic frame(input int addr, input bit rd, input int nbits, input bit close);
        int         len;
        bit         valid;
        logic [3:0] a;
        logic       d, es;
        len   = (addr == NBUFS) ? NGLOBAL*WIDTH : BUFSIZE*WIDTH;
        valid = (addr <= NBUFS);
        a     = 4'(addr);
        for (int i = AW-1; i >= 0; i--) step(1'b1, a[i], 1'b0, 1'b0, 1'b0);
        step(1'b1, rd, (rd && valid) ? model_bit(addr, 0) : 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i >= len) d = 1'b1;
            else if (rd)  d = i[0];
            else          d = wbuf[i/8][7-i%8];
            es = (rd && valid && i + 1 < len) ? model_bit(addr, i + 1) : 1'b0;
            step(1'b1, d, es, 1'b0, i == len);
        end
        if (close) begin
            pend_addr = addr;
            pend_w    = wbuf;
            step(1'b0, 1'b0, 1'b0, !rd && valid && nbits == len,
                 (nbits < len) ? !rd : (nbits == len && !valid));
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        sif.ssel = 1'b0;
        clear_model();
        exp_sout = 1'b0; exp_commit = 1'b0; exp_err = 1'b0; exp_field = 8'h00;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic sweep_fields(input logic [2:0] b);
        bufp = b;
        for (int f = 0; f < 32; f++) begin
            fieldp = 5'(f);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; sif.ssel = 1'b0; sif.sin = 1'b0; bufp = '0; fieldp = '0;
        clear_model();
        exp_sout = 1'b0; exp_commit = 1'b0; exp_err = 1'b0; exp_field = 8'h00;
        #2 rst = 1'b1;
        repeat (2) @(posedge sclk);
        #1 rst = 1'b0;
        checking = 1'b1;

        // Reset in the middle of a write to buffer 3.
        for (int w = 0; w < BUFSIZE; w++) wbuf[w] = 8'hFF;
        frame(3, 1'b0, 100, 1'b0);
        do_reset(2);
        check("rst_field_byte", 32'(field_byte), 32'h0);
        check("rst_pseq", 32'(pattern_sequence), 32'h0);
        check("rst_sout", 32'(sif.sout), 32'h0);
        sweep_fields(3'd3);

        // Buffer 2 write, immediately followed by a globals write.
        for (int w = 0; w < BUFSIZE; w++) wbuf[w] = 8'(w);
        bufp = 3'd2; fieldp = 5'd3;
        frame(2, 1'b0, 216, 1'b1);
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbuf[2] = 8'h0F;
        frame(8, 1'b0, 24, 1'b1);
        check("glb_pseq", 32'(pattern_sequence), 32'h0F3CA5);
        fieldp = 5'd1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("glb_field1", 32'(field_byte), 32'h3C);
        fieldp = 5'd3;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("buf2_word0", 32'(field_byte), 32'h00);
        fieldp = 5'd29;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("buf2_word26", 32'(field_byte), 32'h1A);
        check("commits_after_load", 32'(n_commit_seen), 32'd2);

        // Buffer 5: good load, then short and long frames that must not change it.
        for (int w = 0; w < BUFSIZE; w++) wbuf[w] = 8'h80 + 8'(w);
        frame(5, 1'b0, 216, 1'b1);
        for (int w = 0; w < BUFSIZE; w++) wbuf[w] = 8'h55;
        frame(5, 1'b0, 215, 1'b1);
        frame(5, 1'b0, 217, 1'b1);
        bufp = 3'd5; fieldp = 5'd7;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("buf5_word4", 32'(field_byte), 32'h84);
        sweep_fields(3'd5);

        // Readback of buffer 2 and the globals, plus a short read.
        frame(2, 1'b1, 216, 1'b1);
        frame(8, 1'b1, 24, 1'b1);
        frame(2, 1'b1, 50, 1'b1);

        // Out-of-range address write.
        for (int w = 0; w < BUFSIZE; w++) wbuf[w] = 8'h77;
        frame(9, 1'b0, 216, 1'b1);
        fieldp = 5'd31;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("field31", 32'(field_byte), 32'h00);
        for (int b = 0; b < NBUFS; b++) sweep_fields(3'(b));

        // Commit while the same word is being fetched.
        for (int w = 0; w < BUFSIZE; w++) wbuf[w] = 8'hFF - 8'(w);
        bufp = 3'd2; fieldp = 5'd3;
        frame(2, 1'b0, 216, 1'b1);
        check("fetch_on_commit_old", 32'(field_byte), 32'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fetch_after_commit_new", 32'(field_byte), 32'hFF);
        check("total_commits", 32'(n_commit_seen), 32'd4);
        check("total_frame_errs", 32'(n_err_seen), 32'd3);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
